// File: rtl/div_gen_if.sv
// Handshake and data bundle between the EX/HILO logic (master) and the
// multi-cycle divider (slave).
interface div_gen_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic                 start_i;
  logic                 annul_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 div_zero_o;

  modport master (
    output signed_div_i, start_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  signed_div_i, start_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o, div_zero_o
  );
endinterface

// File: rtl/div_gen.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per
// cycle. Result is {remainder, quotient}; held while start_i stays high.
//
//   state  | meaning
//   FREE   | idle, waiting for start_i without annul_i
//   BYZERO | divisor was zero, load the defined divide-by-zero result
//   ON     | restoring iterations (cnt < WIDTH), then sign fixup (cnt == WIDTH)
//   END    | result presented until start_i drops
module div_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  div_gen_if.slave bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 sign1_q;
  logic                 sign2_q;
  logic                 sgn_mode_q;
  logic [WIDTH-1:0]     dividend_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [2*WIDTH:0]     work_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 zero_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 div_zero_q;

  logic [WIDTH-1:0]     abs1_d;
  logic [WIDTH-1:0]     abs2_d;
  logic [WIDTH:0]       trial_d;
  logic [WIDTH-1:0]     quot_raw_d;
  logic [WIDTH-1:0]     rem_raw_d;
  logic [WIDTH-1:0]     quot_fix_d;
  logic [WIDTH-1:0]     rem_fix_d;

  // Operand magnitudes, trial subtraction and sign fixup of the final values.
  // The partial remainder window is the top WIDTH+1 bits so that divisors with
  // the MSB set cannot lose the remainder's top bit on the shift.
  always_comb begin
    abs1_d     = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2_d     = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    trial_d    = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    quot_raw_d = work_q[WIDTH-1:0];
    rem_raw_d  = work_q[2*WIDTH:WIDTH+1];
    quot_fix_d = (sgn_mode_q && (sign1_q ^ sign2_q)) ? -quot_raw_d : quot_raw_d;
    rem_fix_d  = (sgn_mode_q && sign1_q) ? -rem_raw_d : rem_raw_d;
  end

  // Controller FSM with registered result, ready and divide-by-zero outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      sgn_mode_q <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      work_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q    <= 1'b0;
          result_q   <= '0;
          div_zero_q <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            sign1_q    <= bus.opdata1_i[WIDTH-1];
            sign2_q    <= bus.opdata2_i[WIDTH-1];
            sgn_mode_q <= bus.signed_div_i;
            dividend_q <= bus.opdata1_i;
            divisor_q  <= abs2_d;
            if (bus.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
              cnt_q   <= '0;
              work_q  <= {{WIDTH{1'b0}}, abs1_d, 1'b0};
            end
          end
        end
        BYZERO: begin
          quot_q  <= '1;
          rem_q   <= dividend_q;
          zero_q  <= 1'b1;
          state_q <= END;
        end
        ON: begin
          if (bus.annul_i) begin
            state_q <= FREE;
          end else if (cnt_q != CNT_W'(WIDTH)) begin
            if (trial_d[WIDTH]) begin
              work_q <= {work_q[2*WIDTH-1:0], 1'b0};
            end else begin
              work_q <= {trial_d[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            quot_q  <= quot_fix_d;
            rem_q   <= rem_fix_d;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= END;
          end
        end
        END: begin
          // annul_i has no effect once the result exists
          if (!bus.start_i) begin
            state_q    <= FREE;
            ready_q    <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
          end else begin
            ready_q    <= 1'b1;
            result_q   <= {rem_q, quot_q};
            div_zero_q <= zero_q;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  // Output mapping; busy is decoded straight from the state register.
  always_comb begin
    bus.result_o   = result_q;
    bus.ready_o    = ready_q;
    bus.div_zero_o = div_zero_q;
    bus.busy_o     = (state_q != FREE);
  end

endmodule

// File: tb/tb_div_gen.sv
// Directed bench for div_gen: 32-bit and 8-bit instances, hand-computed results.
module tb_div_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_gen_if #(.WIDTH(32)) bus32 ();
  div_gen_if #(.WIDTH(8))  bus8 ();

  div_gen #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  div_gen #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Issue one 32-bit operation, scramble operands after accept, wait for ready,
  // capture outputs, then drop start for one edge.
  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res, output logic dz);
    @(negedge clk);
    bus32.signed_div_i = sgn;
    bus32.opdata1_i    = a;
    bus32.opdata2_i    = b;
    bus32.annul_i      = 1'b0;
    bus32.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus32.opdata1_i = ~a;
    bus32.opdata2_i = 32'h3;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o) begin
        lat = k;
        break;
      end
    end
    res = bus32.result_o;
    dz  = bus32.div_zero_o;
    @(negedge clk);
    bus32.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy32: got %b expected 0", bus32.busy_o); end
    n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready32: got %b expected 0", bus32.ready_o); end
    n_checks++; if (bus32.result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result32: got %h expected 0", bus32.result_o); end
    n_checks++; if (bus32.div_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz32: got %b expected 0", bus32.div_zero_o); end
    n_checks++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", bus8.busy_o); end
    n_checks++; if (bus8.result_o !== 16'h0) begin n_fail++; $display("FAIL reset_result8: got %h expected 0", bus8.result_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    int bad_busy;
    int bad_hold;
    logic [63:0] res;
    logic dz;
    @(negedge clk);
    bus32.signed_div_i = 1'b0;
    bus32.opdata1_i    = 32'd100;
    bus32.opdata2_i    = 32'd7;
    bus32.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus32.opdata1_i = 32'd5;
    bus32.opdata2_i = 32'd1;
    lat = -1;
    bad_busy = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus32.busy_o !== 1'b1) bad_busy++;
      if (bus32.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL u100_7_latency: got %0d expected 34", lat); end
    n_checks++; if (bus32.result_o !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL u100_7_result: got %h expected %h", bus32.result_o, {32'd2, 32'd14}); end
    n_checks++; if (bus32.div_zero_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_dz: got %b expected 0", bus32.div_zero_o); end
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL u100_7_busy: got %0d low cycles expected 0", bad_busy); end
    bad_hold = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o !== 1'b1 || bus32.busy_o !== 1'b1 || bus32.result_o !== {32'd2, 32'd14}) bad_hold++;
    end
    n_checks++; if (bad_hold !== 0) begin n_fail++; $display("FAIL u100_7_hold: got %0d bad cycles expected 0", bad_hold); end
    @(negedge clk);
    bus32.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_drop_ready: got %b expected 0", bus32.ready_o); end
    n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_drop_busy: got %b expected 0", bus32.busy_o); end
    n_checks++; if (bus32.result_o !== 64'h0) begin n_fail++; $display("FAIL u100_7_drop_result: got %h expected 0", bus32.result_o); end
    run32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, lat, res, dz);
    n_checks++; if (res !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL u_big_divisor: got %h expected %h", res, {32'd1, 32'd1}); end
    run32(1'b0, 32'hFFFFFFFF, 32'h80000001, lat, res, dz);
    n_checks++; if (res !== {32'h7FFFFFFE, 32'd1}) begin n_fail++; $display("FAIL u_msb_divisor: got %h expected %h", res, {32'h7FFFFFFE, 32'd1}); end
  endtask

  task automatic test_signed;
    int lat;
    logic [63:0] res;
    logic dz;
    run32(1'b1, 32'hFFFFFFF9, 32'd2, lat, res, dz);
    n_checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL s_m7_2: got %h expected %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL s_m7_2_latency: got %0d expected 34", lat); end
    run32(1'b1, 32'd7, 32'hFFFFFFFE, lat, res, dz);
    n_checks++; if (res !== {32'h00000001, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL s_7_m2: got %h expected %h", res, {32'h00000001, 32'hFFFFFFFD}); end
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res, dz);
    n_checks++; if (res !== {32'h0, 32'h80000000}) begin n_fail++; $display("FAIL s_min_m1: got %h expected %h", res, {32'h0, 32'h80000000}); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL s_min_m1_dz: got %b expected 0", dz); end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [63:0] res;
    logic dz;
    run32(1'b1, 32'hFFFFFFFB, 32'h0, lat, res, dz);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", dz); end
    n_checks++; if (res !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL dz_result: got %h expected %h", res, {32'hFFFFFFFB, 32'hFFFFFFFF}); end
    n_checks++; if (bus32.div_zero_o !== 1'b0) begin n_fail++; $display("FAIL dz_cleared: got %b expected 0", bus32.div_zero_o); end
  endtask

  task automatic test_annul;
    int lat;
    logic rdy_seen;
    @(negedge clk);
    bus32.signed_div_i = 1'b0;
    bus32.opdata1_i    = 32'd1000000;
    bus32.opdata2_i    = 32'd7;
    bus32.start_i      = 1'b1;
    @(posedge clk);
    #1;
    rdy_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      rdy_seen = rdy_seen | bus32.ready_o;
    end
    bus32.annul_i = 1'b1;
    @(posedge clk);
    #1;
    rdy_seen = rdy_seen | bus32.ready_o;
    n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_busy: got %b expected 0", bus32.busy_o); end
    n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL annul_ready: got %b expected 0", rdy_seen); end
    @(negedge clk);
    bus32.annul_i   = 1'b0;
    bus32.opdata1_i = 32'd9;
    bus32.opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    n_checks++; if (bus32.busy_o !== 1'b1) begin n_fail++; $display("FAIL annul_restart_busy: got %b expected 1", bus32.busy_o); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL annul_restart_latency: got %0d expected 34", lat); end
    n_checks++; if (bus32.result_o !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_restart_result: got %h expected %h", bus32.result_o, {32'd0, 32'd3}); end
    @(negedge clk);
    bus32.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    int lat;
    @(negedge clk);
    bus32.signed_div_i = 1'b0;
    bus32.opdata1_i    = 32'd100;
    bus32.opdata2_i    = 32'd7;
    bus32.start_i      = 1'b1;
    for (int k = 0; k < 6; k++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_on_busy: got %b expected 0", bus32.busy_o); end
    n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL arst_on_ready: got %b expected 0", bus32.ready_o); end
    bus32.opdata1_i = 32'd20;
    bus32.opdata2_i = 32'd4;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus32.busy_o !== 1'b1) begin n_fail++; $display("FAIL arst_first_accept: got %b expected 1", bus32.busy_o); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (bus32.result_o !== {32'd0, 32'd5}) begin n_fail++; $display("FAIL arst_after_result: got %h expected %h", bus32.result_o, {32'd0, 32'd5}); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL arst_end_ready: got %b expected 0", bus32.ready_o); end
    n_checks++; if (bus32.result_o !== 64'h0) begin n_fail++; $display("FAIL arst_end_result: got %h expected 0", bus32.result_o); end
    n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_end_busy: got %b expected 0", bus32.busy_o); end
    bus32.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_width8;
    int lat;
    @(negedge clk);
    bus8.signed_div_i = 1'b0;
    bus8.opdata1_i    = 8'd200;
    bus8.opdata2_i    = 8'd3;
    bus8.annul_i      = 1'b0;
    bus8.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus8.opdata1_i = 8'd1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus8.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL w8_latency: got %0d expected 10", lat); end
    n_checks++; if (bus8.result_o !== {8'd2, 8'd66}) begin n_fail++; $display("FAIL w8_200_3: got %h expected %h", bus8.result_o, {8'd2, 8'd66}); end
    @(negedge clk);
    bus8.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus8.ready_o !== 1'b0) begin n_fail++; $display("FAIL w8_drop_ready: got %b expected 0", bus8.ready_o); end
    n_checks++; if (bus8.result_o !== 16'h0) begin n_fail++; $display("FAIL w8_drop_result: got %h expected 0", bus8.result_o); end
    @(negedge clk);
    bus8.signed_div_i = 1'b1;
    bus8.opdata1_i    = 8'h80;
    bus8.opdata2_i    = 8'hFF;
    bus8.start_i      = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus8.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL w8_min_latency: got %0d expected 10", lat); end
    n_checks++; if (bus8.result_o !== {8'h00, 8'h80}) begin n_fail++; $display("FAIL w8_min_m1: got %h expected %h", bus8.result_o, {8'h00, 8'h80}); end
    @(negedge clk);
    bus8.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    int bad_hold;
    logic [63:0] res;
    logic dz;
    @(negedge clk);
    bus32.signed_div_i = 1'b0;
    bus32.opdata1_i    = 32'd50;
    bus32.opdata2_i    = 32'd5;
    bus32.start_i      = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (bus32.result_o !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", bus32.result_o, {32'd0, 32'd10}); end
    bus32.opdata1_i = 32'd99;
    bus32.opdata2_i = 32'd2;
    bad_hold = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus32.ready_o !== 1'b1 || bus32.result_o !== {32'd0, 32'd10}) bad_hold++;
    end
    n_checks++; if (bad_hold !== 0) begin n_fail++; $display("FAIL b2b_no_restart: got %0d bad cycles expected 0", bad_hold); end
    @(negedge clk);
    bus32.start_i = 1'b0;
    @(posedge clk);
    #1;
    run32(1'b0, 32'd99, 32'd2, lat, res, dz);
    n_checks++; if (res !== {32'd1, 32'd49}) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", res, {32'd1, 32'd49}); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    bus32.signed_div_i = 1'b0;
    bus32.start_i      = 1'b0;
    bus32.annul_i      = 1'b0;
    bus32.opdata1_i    = '0;
    bus32.opdata2_i    = '0;
    bus8.signed_div_i  = 1'b0;
    bus8.start_i       = 1'b0;
    bus8.annul_i       = 1'b0;
    bus8.opdata1_i     = '0;
    bus8.opdata2_i     = '0;
    #1;
    rst = 1'b1;
    #10;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_width8();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_gen.md
Name: div_gen

Overview:
- Parametrised successor to the 32-bit multi-cycle restoring divider in the execute stage: same start/annul/ready handshake to the EX/HILO logic, operand width generalised to WIDTH.
- Adds explicit busy and divide-by-zero indications, defined divide-by-zero results, and a separated quotient/remainder result.
- Sits beside the ALU. EX stalls while busy_o=1 and writes {remainder, quotient} to HI/LO when ready_o=1.

Parameters:
- WIDTH, 32, operand width in bits (>=2); quotient and remainder are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned
- start_i  in  1  request; held high until result consumed
- annul_i  in  1  cancel (pipeline flush)
- opdata1_i  in  WIDTH  dividend, sampled on accept edge only
- opdata2_i  in  WIDTH  divisor, sampled on accept edge only
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid
- busy_o  out  1  high in every state other than FREE
- div_zero_o  out  1  high with ready_o when the divisor was zero

Behaviour:
- Reset (async, any state): state=FREE, cnt=0, sign regs=0, result_o=0, ready_o=0, div_zero_o=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - Accept when start_i=1 and annul_i=0. On the accept edge latch sign1/sign2 and the absolute values of both operands (negate only when signed_div_i=1 and the MSB is set), and latch signed_div_i as sgn_mode.
  - Divisor==0 -> BYZERO; otherwise -> ON with cnt=0 and a 2*WIDTH+1 working register = {0, |op1|, 0}.
  - No accept -> ready_o=0, result_o=0, div_zero_o=0.
- ON, annul_i=1: -> FREE at the next edge. No ready_o; result_o is not updated.
- ON, cnt<WIDTH: one restoring step per cycle.
  - Compute a WIDTH+1-bit trial = upper partial remainder minus divisor.
  - Trial MSB=1 -> shift left, inserting 0.
  - Otherwise load trial[WIDTH-1:0] into the upper part, shift, and insert 1.
  - cnt++.
- ON, cnt==WIDTH: fixup cycle.
  - If sgn_mode and sign1^sign2, negate the quotient.
  - If sgn_mode and sign1=1, negate the remainder, so the remainder takes the dividend's sign.
  - -> END, cnt=0.
- BYZERO: quotient = all ones, remainder = original opdata1 as latched (not the absolute value) -> END, with the div_zero flag set.
- END:
  - Each cycle: result_o={rem,quot}, ready_o=1, div_zero_o=flag.
  - When start_i=0 -> FREE, with ready_o, result_o and div_zero_o cleared on that same edge.
  - annul_i is ignored in END.
- Latency: with the accept edge at N, normal results have ready_o=1 first after edge N+WIDTH+2; divide-by-zero results after edge N+2.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the algorithm with no special case.
- Operand changes after the accept edge have no effect on the operation in flight.
- start_i held high through END does not start a new operation. A new start is accepted only from FREE.

Test Plan:
- WIDTH=32, unsigned, 100/7, accept at edge N -> ready_o rises after N+34; result_o={32'd2, 32'd14}, div_zero_o=0; busy_o=1 from N+1 until start_i drops.
- WIDTH=32, signed:
  - -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
  - 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero, signed, opdata1=0xFFFFFFFB, opdata2=0 -> ready_o after N+2 with div_zero_o=1; result_o={0xFFFFFFFB, 0xFFFFFFFF}.
- Annul: assert annul_i at iteration cnt=10 -> state FREE next edge, ready_o never rises. An immediate new start 9/3 then completes with quotient 3, remainder 0.
- Async reset mid-ON (asserted between edges) -> outputs zero immediately without waiting for an edge; the block accepts a start on the first edge after release.
- WIDTH=8 instance, unsigned 200/3 -> result_o={8'd2, 8'd66}, ready after N+10. Dropping start_i in END clears ready_o and result_o on the next edge.
